// File: rtl/uart_tx_byte_fifo.sv
// uart_tx_byte_fifo: byte FIFO and launch sequencer in front of the UART transmitter.
// Latency: a byte offered in cycle n into an empty FIFO with the FSM idle is launched (o_Tx_DV) in cycle n+2.
// Backpressure: o_Wr_Ready is low while the FIFO is full; a pop in the same cycle does not free a slot until the next cycle.
//
// Ports:
//   i_Clock, reset            clock; synchronous active-high reset
//   i_Wr_Valid/i_Wr_Byte      producer write port (handshake with o_Wr_Ready)
//   o_Tx_DV/o_Tx_Byte         1-cycle launch strobe and byte to the transmitter (byte held until next launch)
//   i_Tx_Active               transmitter busy status (observed only)
//   i_Tx_Done                 1-cycle pulse at end of stop bit
//   o_Count/o_Empty/o_Busy    occupancy and activity status
//   i_Flush                   present only when UART_TX_FIFO_FLUSH_EN is defined: clears the queue
module uart_tx_byte_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              reset,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic              i_Flush,
`endif
  input  logic              i_Wr_Valid,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Wr_Ready,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Empty,
  output logic              o_Busy
);

  typedef enum logic {
    S_IDLE,
    S_WAIT_DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];

  logic flush;
  logic wr_ready;
  logic push;
  logic pop;

  // The transmitter's busy flag is status only; launch timing is driven by i_Tx_Done.
  logic unused_tx_active;
  assign unused_tx_active = i_Tx_Active;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign flush = i_Flush;
`else
  assign flush = 1'b0;
`endif

  // Ready comes from the registered count so a same-cycle pop never frees a slot early.
  assign wr_ready = (count_q != FULL_COUNT) && !flush;
  assign push     = i_Wr_Valid && wr_ready;
  // Pop only from idle; flush suppresses any launch in its cycle.
  assign pop      = (state_q == S_IDLE) && (count_q != '0) && !flush;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    mem_d     = mem_q;

    // Launch FSM: flush leaves state and the launched byte untouched.
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
          state_d   = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = i_Wr_Byte;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge i_Clock) begin
    mem_q <= mem_d;
  end

  assign o_Wr_Ready = wr_ready;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Count    = count_q;
  assign o_Empty    = (count_q == '0);
  assign o_Busy     = (count_q != '0) || (state_q == S_WAIT_DONE);

endmodule

// File: tb/tb_uart_tx_byte_fifo.sv
// Testbench for uart_tx_byte_fifo: directed steps, scoreboard of accepted bytes,
// and a behavioural UART transmitter that serialises each launched byte.
module tb_uart_tx_byte_fifo;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int BIT_CLKS = 4;

  logic              i_Clock = 1'b0;
  logic              reset;
  logic              i_Wr_Valid;
  logic [7:0]        i_Wr_Byte;
  logic              o_Wr_Ready;
  logic              o_Tx_DV;
  logic [7:0]        o_Tx_Byte;
  logic              i_Tx_Active;
  logic              i_Tx_Done;
  logic [ADDR_W:0]   o_Count;
  logic              o_Empty;
  logic              o_Busy;
`ifdef UART_TX_FIFO_FLUSH_EN
  logic              i_Flush;
`endif

  logic       tx_line;
  logic [7:0] sb [$];
  int         n_total  = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         n_launch = 0;

  always #5 i_Clock = ~i_Clock;

  uart_tx_byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_Clock     (i_Clock),
    .reset       (reset),
`ifdef UART_TX_FIFO_FLUSH_EN
    .i_Flush     (i_Flush),
`endif
    .i_Wr_Valid  (i_Wr_Valid),
    .i_Wr_Byte   (i_Wr_Byte),
    .o_Wr_Ready  (o_Wr_Ready),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Active (i_Tx_Active),
    .i_Tx_Done   (i_Tx_Done),
    .o_Count     (o_Count),
    .o_Empty     (o_Empty),
    .o_Busy      (o_Busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural transmitter: takes each launch, checks it against the scoreboard,
  // drives a 10-bit frame on tx_line, re-samples it mid-bit, then pulses i_Tx_Done.
  initial begin : tx_model
    logic [7:0] got;
    logic [7:0] exp;
    logic [9:0] frame;
    logic [9:0] rxf;
    logic       aborted;
    logic       dv_extra;
    i_Tx_Active = 1'b0;
    i_Tx_Done   = 1'b0;
    tx_line     = 1'b1;
    forever begin
      @(negedge i_Clock);
      if (!reset && o_Tx_DV) begin
        n_launch++;
        got = o_Tx_Byte;
        if (sb.size() == 0) begin
          check("no_launch_expected", o_Tx_DV, 0);
          exp = 8'h00;
        end else begin
          exp = sb.pop_front();
          check("tx_byte_order", got, exp);
        end
        frame       = {1'b1, got, 1'b0};
        rxf         = '0;
        aborted     = 1'b0;
        dv_extra    = 1'b0;
        i_Tx_Active = 1'b1;
        for (int b = 0; b < 10 && !aborted; b++) begin
          tx_line = frame[b];
          for (int c = 0; c < BIT_CLKS && !aborted; c++) begin
            @(negedge i_Clock);
            if (reset) aborted = 1'b1;
            if (o_Tx_DV) dv_extra = 1'b1;
            if (c == BIT_CLKS / 2) rxf[b] = tx_line;
          end
        end
        tx_line = 1'b1;
        if (!aborted) begin
          check("single_strobe_no_early_launch", {31'd0, dv_extra}, 0);
          check("serial_frame_lsb_first", {22'd0, rxf}, {22'd0, 1'b1, exp, 1'b0});
          i_Tx_Done = 1'b1;
          @(negedge i_Clock);
          i_Tx_Done = 1'b0;
        end
        i_Tx_Active = 1'b0;
      end
    end
  end

  // Offer a byte and hold it until accepted (bounded).
  task automatic push_hold(input logic [7:0] b, input int budget);
    int w;
    w = 0;
    @(negedge i_Clock);
    i_Wr_Valid = 1'b1;
    i_Wr_Byte  = b;
    while (!o_Wr_Ready && w < budget) begin
      @(negedge i_Clock);
      w++;
    end
    if (o_Wr_Ready) sb.push_back(b);
    else check("push_accept_timeout", {31'd0, o_Wr_Ready}, 1);
  endtask

  task automatic release_wr();
    @(negedge i_Clock);
    i_Wr_Valid = 1'b0;
  endtask

  task automatic wait_dv(input int budget);
    int w;
    w = 0;
    do begin
      @(negedge i_Clock);
      w++;
    end while (!o_Tx_DV && w < budget);
    check("launch_seen", {31'd0, o_Tx_DV}, 1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int w;
    w = 0;
    while (!(o_Empty && !o_Busy && sb.size() == 0) && w < budget) begin
      @(negedge i_Clock);
      w++;
    end
    check({tag, "_empty"}, {31'd0, o_Empty}, 1);
    check({tag, "_busy"}, {31'd0, o_Busy}, 0);
    check({tag, "_count"}, {27'd0, o_Count}, 0);
    check({tag, "_sb_left"}, sb.size(), 0);
  endtask

  // Launch a lead byte so the FSM sits in S_WAIT_DONE, then fill all 16 slots.
  task automatic fill_full(input logic [7:0] lead, input logic [7:0] base);
    push_hold(lead, 2);
    release_wr();
    wait_dv(10);
    for (int i = 0; i < DEPTH; i++) push_hold(base + 8'(i), 1);
    release_wr();
    check("fill_count_16", {27'd0, o_Count}, DEPTH);
    check("fill_ready_low", {31'd0, o_Wr_Ready}, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    int launches_before;
    reset      = 1'b1;
    i_Wr_Valid = 1'b0;
    i_Wr_Byte  = 8'h00;
`ifdef UART_TX_FIFO_FLUSH_EN
    i_Flush    = 1'b0;
`endif
    repeat (3) @(negedge i_Clock);
    check("rst_tx_dv", {31'd0, o_Tx_DV}, 0);
    check("rst_tx_byte", {24'd0, o_Tx_Byte}, 8'h00);
    check("rst_count", {27'd0, o_Count}, 0);
    check("rst_empty", {31'd0, o_Empty}, 1);
    check("rst_wr_ready", {31'd0, o_Wr_Ready}, 1);
    check("rst_busy", {31'd0, o_Busy}, 0);
    reset = 1'b0;
    repeat (6) @(negedge i_Clock);

    // 1: single byte, launch two cycles after it is offered
    push_hold(8'hA5, 2);
    release_wr();
    check("t1_dv_n1", {31'd0, o_Tx_DV}, 0);
    check("t1_count_n1", {27'd0, o_Count}, 1);
    @(negedge i_Clock);
    check("t1_dv_n2", {31'd0, o_Tx_DV}, 1);
    check("t1_byte_n2", {24'd0, o_Tx_Byte}, 8'hA5);
    @(negedge i_Clock);
    check("t1_dv_n3", {31'd0, o_Tx_DV}, 0);
    check("t1_byte_held", {24'd0, o_Tx_Byte}, 8'hA5);
    check("t1_busy_in_flight", {31'd0, o_Busy}, 1);
    wait_drain("t1", 200);

    // 2: burst of 16 while a lead byte is in flight, 17th byte held off
    fill_full(8'hEE, 8'h00);
    @(negedge i_Clock);
    i_Wr_Valid = 1'b1;
    i_Wr_Byte  = 8'h10;
    check("t2_ready_low_17th", {31'd0, o_Wr_Ready}, 0);
    repeat (5) @(negedge i_Clock);
    check("t2_held_count", {27'd0, o_Count}, DEPTH);
    push_hold(8'h10, 300);
    release_wr();
    wait_drain("t2", 2000);

    // 3: push and pop in the same cycle with count 3
    for (int i = 0; i < 4; i++) push_hold(8'h30 + 8'(i), 1);
    release_wr();
    check("t3_pre_count", {27'd0, o_Count}, 3);
    w = 0;
    do begin
      @(posedge i_Clock);
      w++;
    end while (!i_Tx_Done && w < 200);
    check("t3_done_seen", {31'd0, i_Tx_Done}, 1);
    @(negedge i_Clock);
    check("t3_count_before", {27'd0, o_Count}, 3);
    i_Wr_Valid = 1'b1;
    i_Wr_Byte  = 8'h34;
    if (o_Wr_Ready) sb.push_back(8'h34);
    @(negedge i_Clock);
    i_Wr_Valid = 1'b0;
    check("t3_count_pushpop", {27'd0, o_Count}, 3);
    check("t3_dv", {31'd0, o_Tx_DV}, 1);
    check("t3_byte", {24'd0, o_Tx_Byte}, 8'h31);
    wait_drain("t3", 1000);

    // 4: fill, drain, refill across the pointer wrap
    fill_full(8'hC0, 8'h40);
    wait_drain("t4a", 2000);
    fill_full(8'hC1, 8'h80);
    wait_drain("t4b", 2000);

    // 5: reset mid data-bit with 5 bytes queued
    push_hold(8'h55, 2);
    release_wr();
    wait_dv(10);
    for (int i = 0; i < 5; i++) push_hold(8'h60 + 8'(i), 1);
    release_wr();
    repeat (8) @(negedge i_Clock);
    reset = 1'b1;
    sb.delete();
    repeat (2) @(negedge i_Clock);
    check("t5_count", {27'd0, o_Count}, 0);
    check("t5_dv", {31'd0, o_Tx_DV}, 0);
    check("t5_busy_idle", {31'd0, o_Busy}, 0);
    check("t5_ready", {31'd0, o_Wr_Ready}, 1);
    reset = 1'b0;
    @(negedge i_Clock);
    push_hold(8'h3C, 2);
    release_wr();
    wait_dv(10);
    check("t5_new_byte", {24'd0, o_Tx_Byte}, 8'h3C);
    wait_drain("t5", 500);

`ifdef UART_TX_FIFO_FLUSH_EN
    // 6: flush with 6 queued and one in flight, concurrent write dropped
    push_hold(8'h90, 2);
    release_wr();
    wait_dv(10);
    for (int i = 0; i < 6; i++) push_hold(8'hA0 + 8'(i), 1);
    @(negedge i_Clock);
    i_Flush    = 1'b1;
    i_Wr_Valid = 1'b1;
    i_Wr_Byte  = 8'h77;
    #1;
    check("t6_ready_in_flush", {31'd0, o_Wr_Ready}, 0);
    @(negedge i_Clock);
    i_Flush    = 1'b0;
    i_Wr_Valid = 1'b0;
    sb.delete();
    launches_before = n_launch;
    check("t6_count", {27'd0, o_Count}, 0);
    check("t6_busy_in_flight", {31'd0, o_Busy}, 1);
    wait_drain("t6", 500);
    repeat (10) @(negedge i_Clock);
    check("t6_no_relaunch", n_launch - launches_before, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
